sr_latch_driver: RTL and testbench

Clocked sequencer that owns the drive side of a gate-level SR latch. It accepts set/reset requests over a valid/ready handshake and converts each one into a timed S or R pulse. After the pulse it waits for the latch to settle, samples Q/Qb through a synchronizer, and reports completion and whether the latch reached the commanded state. It sits between synchronous control logic and the Lab3 SR latch, and guarantees that the forbidden S=R=1 input is never produced.

---
 rtl/sr_latch_driver.sv | 176 +++++++++++++++++
 tb/tb_sr_latch_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked drive sequencer for a gate-level SR latch.
// Each accepted request becomes a PULSE_W-cycle S or R pulse. A settle
// window of SETTLE+2 cycles follows, and then the synchronized Q/Qb are
// checked against the commanded value. S and R are decoded from a
// one-hot-free state/op pair, so both can never be high together.

module sr_latch_driver #(
    parameter int unsigned PULSE_W = 32'd4,
    parameter int unsigned SETTLE  = 32'd2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q,
    input  logic Qb,
    output logic busy,
    output logic done,
    output logic err,
    output logic q_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Counter reload values: PULSE_W cycles of drive, SETTLE+2 cycles of wait
    // (the extra 2 cover the synchronizer latency).
    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 32'd1);
    localparam logic [7:0] WAIT_LOAD  = 8'(SETTLE + 32'd1);

    // The latch reached the commanded state only if both rails agree with op.
    function automatic logic latch_ok(input logic qs, input logic qbs, input logic op);
        return (qs == op) && (qbs == ~op);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       op_q, op_d;

    logic       q_meta_q, qs_q;
    logic       qb_meta_q, qbs_q;

    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       q_state_q, q_state_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       check_edge_s;
    logic       ok_s;

    // Two-flop synchronizers for the asynchronous latch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta_q  <= 1'b0;
            qs_q      <= 1'b0;
            qb_meta_q <= 1'b0;
            qbs_q     <= 1'b0;
        end else begin
            q_meta_q  <= Q;
            qs_q      <= q_meta_q;
            qb_meta_q <= Qb;
            qbs_q     <= qb_meta_q;
        end
    end

    // State register together with the phase counter and captured op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic: accept in IDLE, count down PULSE and WAIT, one CHECK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                    op_d    = req_op;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output decode: drive from the current state, verdict on the WAIT->CHECK edge.
    always_comb begin
        check_edge_s = (state_q == ST_WAIT) && (cnt_q == 8'd0);
        ok_s         = latch_ok(qs_q, qbs_q, op_q);
        s_d          = (state_q == ST_PULSE) && op_q;
        r_d          = (state_q == ST_PULSE) && !op_q;
        done_d       = check_edge_s;
        busy_d       = (state_d != ST_IDLE);
        ready_d      = (state_d == ST_IDLE);
        if (check_edge_s) begin
            err_d     = !ok_s;
            q_state_d = ok_s ? op_q : q_state_q;
        end else begin
            err_d     = 1'b0;
            q_state_d = q_state_q;
        end
    end

    // Registered outputs; reset forces S=R=0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            q_state_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            q_state_q <= q_state_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign q_state   = q_state_q;
    assign busy      = busy_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default instance driving a behavioural
// NOR latch (with a stuck-output override), plus a PULSE_W=1/SETTLE=0 instance.

module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Default-parameter instance signals
    logic req_valid = 1'b0, req_op = 1'b0;
    logic req_ready, S, R, busy, done, err, q_state;
    logic lq = 1'b0, lqb = 1'b1;
    logic stuck = 1'b0, fq = 1'b0, fqb = 1'b1;
    logic dq, dqb;

    // Corner-parameter instance signals
    logic req_valid2 = 1'b0, req_op2 = 1'b0;
    logic req_ready2, S2, R2, busy2, done2, err2, q_state2;
    logic lq2 = 1'b0, lqb2 = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    assign dq  = stuck ? fq  : lq;
    assign dqb = stuck ? fqb : lqb;

    sr_latch_driver #(.PULSE_W(32'd4), .SETTLE(32'd2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready), .S(S), .R(R), .Q(dq), .Qb(dqb),
        .busy(busy), .done(done), .err(err), .q_state(q_state)
    );

    sr_latch_driver #(.PULSE_W(32'd1), .SETTLE(32'd0)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_op(req_op2),
        .req_ready(req_ready2), .S(S2), .R(R2), .Q(lq2), .Qb(lqb2),
        .busy(busy2), .done(done2), .err(err2), .q_state(q_state2)
    );

    // Behavioural NOR latch, 1 ns response, for the default instance
    always @(S or R) begin
        if (S && !R) begin
            #1; lq = 1'b1; lqb = 1'b0;
        end else if (R && !S) begin
            #1; lq = 1'b0; lqb = 1'b1;
        end
    end

    // Behavioural NOR latch, 1 ns response, for the corner instance
    always @(S2 or R2) begin
        if (S2 && !R2) begin
            #1; lq2 = 1'b1; lqb2 = 1'b0;
        end else if (R2 && !S2) begin
            #1; lq2 = 1'b0; lqb2 = 1'b1;
        end
    end

    // Forbidden-input watch on both instances, every cycle including reset
    always @(negedge clk) begin
        n_checks++;
        if ((S && R) || (S2 && R2)) begin
            n_fail++;
            $display("FAIL s_and_r: got S=%b R=%b S2=%b R2=%b want no S&&R", S, R, S2, R2);
        end else begin
            n_pass++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full request on the default instance, checked cycle by cycle.
    task automatic do_request(input logic op, input logic exp_err, input logic exp_qs,
                              input string tag);
        logic p;
        req_op    = op;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            tick();
            p = (j <= 4);
            n_checks++;
            if ({S, R, done, busy, req_ready} !== {p & op, p & !op, (j == 8), (j < 9), (j == 9)}) begin
                n_fail++;
                $display("FAIL %s seq c%0d: got SRdBr=%b want %b", tag, j,
                         {S, R, done, busy, req_ready},
                         {p & op, p & !op, (j == 8), (j < 9), (j == 9)});
            end else begin
                n_pass++;
            end
            if (j == 8) begin
                n_checks++;
                if (err !== exp_err) begin
                    n_fail++;
                    $display("FAIL %s err: got %b want %b", tag, err, exp_err);
                end else begin
                    n_pass++;
                end
            end
        end
        n_checks++;
        if (q_state !== exp_qs) begin
            n_fail++;
            $display("FAIL %s q_state: got %b want %b", tag, q_state, exp_qs);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({S, R, done, err, q_state, busy, req_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b",
                     {S, R, done, err, q_state, busy, req_ready}, 7'b0000001);
        end else begin
            n_pass++;
        end
        n_checks++;
        if ({S2, R2, done2, busy2, req_ready2} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs2: got %b want %b",
                     {S2, R2, done2, busy2, req_ready2}, 5'b00001);
        end else begin
            n_pass++;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_set;
        do_request(1'b1, 1'b0, 1'b1, "set");
    endtask

    task automatic test_reset_op;
        do_request(1'b0, 1'b0, 1'b0, "reset_op");
    endtask

    task automatic test_stuck;
        stuck = 1'b1;
        fq    = 1'b0;
        fqb   = 1'b1;
        do_request(1'b1, 1'b1, 1'b0, "stuck_q0");
        fq    = 1'b1;
        fqb   = 1'b1;
        do_request(1'b1, 1'b1, 1'b0, "stuck_both1");
        stuck = 1'b0;
        repeat (3) tick();
    endtask

    // req_valid held high; op changes right after each expected acceptance.
    task automatic test_back_to_back;
        int  m;
        logic p, opb;
        req_op    = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c % 10 == 0) req_op = ~req_op;
            m   = c % 10;
            p   = (m >= 1) && (m <= 4);
            opb = ((c / 10) % 2 == 0);
            n_checks++;
            if ({S, R, done, req_ready} !== {p & opb, p & !opb, (m == 8), (m == 9)}) begin
                n_fail++;
                $display("FAIL handshake c%0d: got SRdr=%b want %b", c,
                         {S, R, done, req_ready}, {p & opb, p & !opb, (m == 8), (m == 9)});
            end else begin
                n_pass++;
            end
            if (m == 8) begin
                n_checks++;
                if ({err, q_state} !== {1'b0, opb}) begin
                    n_fail++;
                    $display("FAIL handshake_result c%0d: got err,q=%b want %b", c,
                             {err, q_state}, {1'b0, opb});
                end else begin
                    n_pass++;
                end
            end
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        req_op    = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (R !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pulse_R: got %b want %b", R, 1'b1);
        end else begin
            n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({S, R, done, err, q_state, busy, req_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b want %b",
                     {S, R, done, err, q_state, busy, req_ready}, 7'b0000001);
        end else begin
            n_pass++;
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 4) rst_n = 1'b1;
            n_checks++;
            if ({S, R, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_no_done c%0d: got SRd=%b want %b", j, {S, R, done}, 3'b000);
            end else begin
                n_pass++;
            end
        end
        do_request(1'b1, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_corner;
        logic op;
        for (int t = 0; t < 2; t++) begin
            op         = (t == 0);
            req_op2    = op;
            req_valid2 = 1'b1;
            tick();
            req_valid2 = 1'b0;
            for (int j = 1; j <= 5; j++) begin
                tick();
                n_checks++;
                if ({S2, R2, done2, busy2, req_ready2} !==
                    {(j == 1) & op, (j == 1) & !op, (j == 3), (j < 4), (j >= 4)}) begin
                    n_fail++;
                    $display("FAIL corner t%0d c%0d: got SRdBr=%b want %b", t, j,
                             {S2, R2, done2, busy2, req_ready2},
                             {(j == 1) & op, (j == 1) & !op, (j == 3), (j < 4), (j >= 4)});
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_reset_op();
        test_stuck();
        test_back_to_back();
        test_reset_mid();
        test_corner();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
